// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative unsigned multiply,
// divide and remainder, with valid/ready handshakes on both sides.
module alu_mc #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] x_r;    // multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0] y_r;    // multiplier, or divisor
    logic [WIDTH-1:0] acc_r;  // partial product, or partial remainder
    logic [SHW-1:0]   cnt;

    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic             add_v;
    logic             sub_v;
    logic [SHW-1:0]   sh;
    logic             multi;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    // Single-cycle operations, evaluated directly on the input operands.
    always_comb begin
        add_s   = {1'b0, a} + {1'b0, b};
        sub_s   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        add_v   = (a[MSB] == b[MSB]) && (add_s[MSB] != a[MSB]);
        sub_v   = (a[MSB] != b[MSB]) && (sub_s[MSB] != a[MSB]);
        sh      = b[SHW-1:0];
        multi   = (op == 4'd3) || (op == 4'd5) || (op == 4'd9);
        // NOTE: every combinational output gets a default first so no latch is inferred.
        alu_res = add_s[MSB:0];
        alu_c   = add_s[WIDTH];
        alu_v   = add_v;
        case (op)
            4'd1: begin
                alu_res = sub_s[MSB:0];
                alu_c   = sub_s[WIDTH];
                alu_v   = sub_v;
            end
            4'd2:  begin alu_res = a & b;   alu_c = 1'b0; alu_v = 1'b0; end
            4'd4:  begin alu_res = a | b;   alu_c = 1'b0; alu_v = 1'b0; end
            4'd6:  begin alu_res = a ^ b;   alu_c = 1'b0; alu_v = 1'b0; end
            4'd7:  begin alu_res = {{MSB{1'b0}}, sub_s[MSB]};         alu_c = 1'b0; alu_v = 1'b0; end
            4'd8:  begin alu_res = a >> sh; alu_c = 1'b0; alu_v = 1'b0; end
            4'd11: begin alu_res = {{MSB{1'b0}}, sub_s[MSB] ^ sub_v}; alu_c = 1'b0; alu_v = 1'b0; end
            4'd12: begin alu_res = a << sh; alu_c = 1'b0; alu_v = 1'b0; end
            4'd14: begin alu_res = ~a;      alu_c = 1'b0; alu_v = 1'b0; end
            default: ;
        endcase
    end

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
    logic [WIDTH-1:0] nx;
    logic [WIDTH-1:0] ny;
    logic [WIDTH-1:0] nacc;
    logic [WIDTH-1:0] fin;

    // One shift-add or one restoring-division step on the held operands.
    always_comb begin
        rem_sh   = {acc_r, x_r[MSB]};
        rem_diff = rem_sh - {1'b0, y_r};
        nx       = x_r << 1;
        ny       = y_r >> 1;
        nacc     = y_r[0] ? acc_r + x_r : acc_r;
        fin      = nacc;
        if (op_r != 4'd3) begin
            nx   = {x_r[MSB-1:0], ~rem_diff[WIDTH]};
            ny   = y_r;
            nacc = rem_diff[WIDTH] ? rem_sh[MSB:0] : rem_diff[MSB:0];
            fin  = (op_r == 4'd5) ? nx : nacc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: only control and output registers are reset; the datapath
            // operands are always loaded before they are read.
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_ready && in_valid) begin
                        in_ready <= 1'b0;
                        op_r     <= op;
                        if (multi) begin
                            x_r   <= a;
                            y_r   <= b;
                            acc_r <= '0;
                            cnt   <= SHW'(WIDTH - 1);
                            state <= BUSY;
                        end else begin
                            result    <= alu_res;
                            flag_z    <= (alu_res == '0);
                            flag_n    <= alu_res[MSB];
                            flag_c    <= alu_c;
                            flag_v    <= alu_v;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                BUSY: begin
                    x_r   <= nx;
                    y_r   <= ny;
                    acc_r <= nacc;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result    <= fin;
                        flag_z    <= (fin == '0);
                        flag_n    <= fin[MSB];
                        flag_c    <= 1'b0;
                        flag_v    <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Drives a 16-bit and a 32-bit alu_mc in lockstep and checks both against an
// arithmetic reference model.
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [3:0]  op;
    logic [15:0] a16, b16, res16;
    logic [31:0] a32, b32, res32;
    logic        rdy16, vld16, z16, n16, c16, v16;
    logic        rdy32, vld32, z32, n32, c32, v32;

    int checks   = 0;
    int failures = 0;
    longint unsigned last16, last32;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
        .a(a16), .b(b16), .op(op), .out_valid(vld16), .out_ready(out_ready),
        .result(res16), .flag_z(z16), .flag_n(n16), .flag_c(c16), .flag_v(v16)
    );

    alu_mc #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
        .a(a32), .b(b32), .op(op), .out_valid(vld32), .out_ready(out_ready),
        .result(res32), .flag_z(z32), .flag_n(n32), .flag_c(c32), .flag_v(v32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sext(input int w, input longint unsigned x);
        if (((x >> (w - 1)) & 1) != 0) return longint'(x) - (longint'(1) << w);
        return longint'(x);
    endfunction

    // Reference: flags packed as {z, n, c, v}.
    function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                  input logic [3:0] opc, output longint unsigned res,
                                  output logic [3:0] fl);
        longint unsigned mask = (64'd1 << w) - 1;
        longint sa = sext(w, a);
        longint sb = sext(w, b);
        longint smax = (longint'(1) << (w - 1)) - 1;
        longint smin = -(longint'(1) << (w - 1));
        longint r;
        longint unsigned sh = b & longint'(w - 1);
        logic c = 1'b0;
        logic v = 1'b0;
        case (opc)
            4'd1: begin
                res = (a - b) & mask;
                c   = (a >= b);
                r   = sa - sb;
                v   = (r > smax) || (r < smin);
            end
            4'd2:  res = a & b;
            4'd3:  res = (a * b) & mask;
            4'd4:  res = a | b;
            4'd5:  res = (b == 0) ? mask : a / b;
            4'd6:  res = a ^ b;
            4'd7:  res = ((a - b) & mask) >> (w - 1);
            4'd8:  res = a >> sh;
            4'd9:  res = (b == 0) ? a : a % b;
            4'd11: res = (sa < sb) ? 1 : 0;
            4'd12: res = (a << sh) & mask;
            4'd14: res = ~a & mask;
            default: begin
                res = (a + b) & mask;
                c   = ((a + b) >> w) != 0;
                r   = sa + sb;
                v   = (r > smax) || (r < smin);
            end
        endcase
        fl = {res == 0, ((res >> (w - 1)) & 1) != 0, c, v};
    endfunction

    task automatic run(input logic [31:0] av, input logic [31:0] bv, input logic [3:0] opv,
                       input string tag);
        longint unsigned e16, e32;
        logic [3:0] f16, f32;
        logic [15:0] cap16;
        logic [31:0] cap32;
        int t16 = -1;
        int t32 = -1;
        int n = 0;
        model(16, 64'(av[15:0]), 64'(bv[15:0]), opv, e16, f16);
        model(32, 64'(av), 64'(bv), opv, e32, f32);
        while (!(rdy16 && rdy32) && n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_ready"}, {62'd0, rdy16, rdy32}, 64'd3);
        a16 = av[15:0]; b16 = bv[15:0]; a32 = av; b32 = bv; op = opv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a32 = $urandom; b32 = $urandom; a16 = a32[15:0]; b16 = b32[31:16]; op = 4'($urandom);
        for (int k = 0; k <= 40; k++) begin
            if (vld16 && t16 < 0) begin t16 = k; cap16 = res16; end
            if (vld32 && t32 < 0) begin t32 = k; cap32 = res32; end
            if (t16 >= 0 && t32 >= 0) break;
            @(posedge clk); #1;
            a32 = $urandom; b32 = $urandom; a16 = a32[31:16]; b16 = b32[15:0];
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_lat16"}, 64'(t16), (opv == 3 || opv == 5 || opv == 9) ? 64'd16 : 64'd0);
        check({tag, "_lat32"}, 64'(t32), (opv == 3 || opv == 5 || opv == 9) ? 64'd32 : 64'd0);
        check({tag, "_res16"}, 64'(res16), e16);
        check({tag, "_res32"}, 64'(res32), e32);
        check({tag, "_flags16"}, 64'({z16, n16, c16, v16}), 64'(f16));
        check({tag, "_flags32"}, 64'({z32, n32, c32, v32}), 64'(f32));
        check({tag, "_hold"}, {res16, res32, vld16, vld32, rdy16, rdy32},
              {cap16, cap32, 1'b1, 1'b1, 1'b0, 1'b0});
        last16 = 64'(res16);
        last32 = 64'(res32);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_handoff"}, {60'd0, vld16, vld32, rdy16, rdy32}, 64'b0011);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0;
        a16 = '0; b16 = '0; a32 = '0; b32 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset16", {res16, vld16, z16, n16, c16, v16}, '0);
        check("reset32", {res32, vld32, z32, n32, c32, v32}, '0);
        out_ready = 1'b1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", {vld16, vld32, rdy16, rdy32}, 64'b0011);
        out_ready = 1'b0;

        run(32'h7FFF, 32'h1, 4'd0, "add");
        check("tp_add", last16, 64'h8000);
        run(32'h8000, 32'h1, 4'd7, "slt_raw");
        check("tp_slt_raw", last16, 64'd0);
        run(32'h8000, 32'h1, 4'd11, "slt");
        check("tp_slt", last16, 64'd1);
        run(32'd300, 32'd300, 4'd3, "mul");
        check("tp_mul", last16, 64'h5F90);
        run(32'd1000, 32'd7, 4'd5, "div");
        check("tp_div", last16, 64'd142);
        run(32'd1000, 32'd7, 4'd9, "rem");
        check("tp_rem", last16, 64'd6);
        run(32'd1000, 32'd0, 4'd5, "div0");
        check("tp_div0", last16, 64'hFFFF);
        run(32'd1000, 32'd0, 4'd9, "rem0");
        check("tp_rem0", last16, 64'd1000);
        run(32'd1, 32'd31, 4'd12, "shl");
        check("tp_shl32", last32, 64'h8000_0000);
        run(32'hFFFF_FFFF, 32'd2, 4'd3, "mul32");
        check("tp_mul32", last32, 64'hFFFF_FFFE);
        run(32'd5, 32'd9, 4'd1, "sub");
        run(32'h1234_F0F0, 32'h0FF0_1234, 4'd2, "and");
        run(32'h1234_F0F0, 32'h0FF0_1234, 4'd6, "xor");
        run(32'h8000_8000, 32'd3, 4'd8, "shr");
        run(32'hFFFF_FFFF, 32'd1, 4'd13, "op13");

        // Reset during a long operation drops it with no output.
        in_valid = 1'b1; a16 = 16'd99; b16 = 16'd77; a32 = 32'd99; b32 = 32'd77; op = 4'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("busy_reset16", {res16, vld16, z16, n16, c16, v16, rdy16}, '0);
        check("busy_reset32", {res32, vld32, z32, n32, c32, v32, rdy32}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_busy_reset", {vld16, vld32, rdy16, rdy32}, 64'b0011);
        run(32'd12, 32'd5, 4'd9, "rem_after_reset");

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra = $urandom;
            logic [31:0] rb = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            run(ra, rb, 4'($urandom_range(0, 15)), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
